// File: rtl/package_settings.sv
// Shared widths, FSM state encoding and event record for the trapezoidal peak detector.
package package_settings;

    localparam int SIZE_FILTER_DATA = 24;
    localparam int TS_W_DEF         = 32;
    localparam int CNT_W_DEF        = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DEAD  = 2'd2
    } peak_state_t;

    typedef struct packed {
        logic signed [SIZE_FILTER_DATA-1:0] amp;
        logic        [TS_W_DEF-1:0]         ts;
    } peak_event_t;

endpackage

// File: rtl/peak_event_buffer.sv
// One-entry ready/valid holding register for detected events; counts events
// that arrive while the entry is occupied and not being drained.
module peak_event_buffer #(
    parameter int AMP_W = 24,
    parameter int TS_W  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [AMP_W-1:0] i_amp,
    input  logic [TS_W-1:0]  i_ts,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [AMP_W-1:0] o_amp,
    output logic [TS_W-1:0]  o_ts,
    output logic [CNT_W-1:0] o_drop_cnt
);

    logic             r_valid;
    logic [AMP_W-1:0] r_amp;
    logic [TS_W-1:0]  r_ts;
    logic [CNT_W-1:0] r_drop_cnt;
    logic             w_can_load;

    // A transfer in the same cycle frees the slot for the incoming event.
    assign w_can_load = !r_valid || i_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid    <= 1'b0;
            r_amp      <= '0;
            r_ts       <= '0;
            r_drop_cnt <= '0;
        end else if (i_load && w_can_load) begin
            r_valid <= 1'b1;
            r_amp   <= i_amp;
            r_ts    <= i_ts;
        end else begin
            if (i_load && (r_drop_cnt != '1))
                r_drop_cnt <= r_drop_cnt + CNT_W'(1);
            if (r_valid && i_ready)
                r_valid <= 1'b0;
        end
    end

    assign o_valid    = r_valid;
    assign o_amp      = r_amp;
    assign o_ts       = r_ts;
    assign o_drop_cnt = r_drop_cnt;

endmodule

// File: rtl/trap_peak_detector.sv
// Pulse detector on the trapezoidal filter output: hysteresis threshold, flat-top
// maximum tracking with timestamp, pile-up rejection and a post-event dead time.
module trap_peak_detector
    import package_settings::*;
#(
    parameter int FILTER_W  = SIZE_FILTER_DATA,
    parameter int TS_W      = TS_W_DEF,
    parameter int MAX_WIDTH = 64,
    parameter int DEAD_TIME = 16,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic signed [FILTER_W-1:0] in_data,
    input  logic                       in_valid,
    input  logic signed [FILTER_W-1:0] threshold,
    input  logic        [FILTER_W-2:0] hyst,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [FILTER_W-1:0] out_amp,
    output logic        [TS_W-1:0]     out_ts,
    output logic        [CNT_W-1:0]    drop_cnt,
    output logic        [CNT_W-1:0]    pileup_cnt,
    output logic                       busy
);

    localparam int WID_W  = $clog2(MAX_WIDTH + 1);
    localparam int DCNT_W = $clog2(DEAD_TIME + 1);

    peak_state_t         r_state, state_next;
    logic [FILTER_W-1:0] r_thr, thr_next;
    logic [FILTER_W-1:0] r_max, max_next;
    logic [TS_W-1:0]     r_max_ts, max_ts_next;
    logic [WID_W-1:0]    r_width, width_next;
    logic [DCNT_W-1:0]   r_dcnt, dcnt_next;
    logic [TS_W-1:0]     r_ts;
    logic [CNT_W-1:0]    r_pileup_cnt;
    logic                w_evt_done;
    logic                w_pileup;

    // One extra bit so that thr_l - hyst can never wrap.
    logic signed [FILTER_W:0] w_sample_x, w_arm_x, w_max_x, w_end_x;
    logic [WID_W-1:0]         w_width_inc;
    logic [DCNT_W-1:0]        w_dcnt_inc;

    assign w_sample_x  = {in_data[FILTER_W-1], in_data};
    assign w_arm_x     = {threshold[FILTER_W-1], threshold};
    assign w_max_x     = {r_max[FILTER_W-1], r_max};
    assign w_end_x     = {r_thr[FILTER_W-1], r_thr} - {2'b00, hyst};
    assign w_width_inc = r_width + WID_W'(1);
    assign w_dcnt_inc  = r_dcnt + DCNT_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_thr        <= '0;
            r_max        <= '0;
            r_max_ts     <= '0;
            r_width      <= '0;
            r_dcnt       <= '0;
            r_ts         <= '0;
            r_pileup_cnt <= '0;
        end else if (in_valid) begin
            r_state  <= state_next;
            r_thr    <= thr_next;
            r_max    <= max_next;
            r_max_ts <= max_ts_next;
            r_width  <= width_next;
            r_dcnt   <= dcnt_next;
            r_ts     <= r_ts + TS_W'(1);
            if (w_pileup && (r_pileup_cnt != '1))
                r_pileup_cnt <= r_pileup_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        state_next  = r_state;
        thr_next    = r_thr;
        max_next    = r_max;
        max_ts_next = r_max_ts;
        width_next  = r_width;
        dcnt_next   = r_dcnt;
        w_evt_done  = 1'b0;
        w_pileup    = 1'b0;
        if (in_valid) begin
            case (r_state)
                IDLE: begin
                    if (w_sample_x > w_arm_x) begin
                        state_next  = ARMED;
                        thr_next    = threshold;
                        max_next    = in_data;
                        max_ts_next = r_ts;
                        width_next  = WID_W'(1);
                    end
                end
                ARMED: begin
                    if (w_sample_x < w_end_x) begin
                        state_next = DEAD;
                        dcnt_next  = '0;
                        w_evt_done = 1'b1;
                    end else begin
                        if (w_sample_x > w_max_x) begin
                            max_next    = in_data;
                            max_ts_next = r_ts;
                        end
                        width_next = w_width_inc;
                        if (w_width_inc == WID_W'(MAX_WIDTH)) begin
                            state_next = DEAD;
                            dcnt_next  = '0;
                            w_pileup   = 1'b1;
                        end
                    end
                end
                DEAD: begin
                    if (w_dcnt_inc == DCNT_W'(DEAD_TIME)) begin
                        state_next = IDLE;
                        dcnt_next  = '0;
                    end else begin
                        dcnt_next = w_dcnt_inc;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    peak_event_buffer #(
        .AMP_W (FILTER_W),
        .TS_W  (TS_W),
        .CNT_W (CNT_W)
    ) u_buffer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_evt_done),
        .i_amp      (r_max),
        .i_ts       (r_max_ts),
        .i_ready    (out_ready),
        .o_valid    (out_valid),
        .o_amp      (out_amp),
        .o_ts       (out_ts),
        .o_drop_cnt (drop_cnt)
    );

    assign pileup_cnt = r_pileup_cnt;
    assign busy       = (r_state != IDLE);

endmodule
